// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, keeps one imem read in flight and
// buffers returned words with their PC for decode; redirects flush everything.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic [31:0]   r_buf_data [DEPTH];
    logic [31:0]   r_buf_pc   [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_credit;

    assign w_grant = (r_state == S_REQ) && imem_gnt;
    assign w_push  = (r_state == S_WAIT) && imem_rvalid && !redirect;
    assign w_pop   = instr_valid && instr_ready && !redirect;

    // Occupancy after this cycle's push/pop; a new request may launch only
    // if it still leaves a free slot for its response.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    assign w_credit = (w_count_next < DEPTH_C);

    always_comb begin
        w_state_next = r_state;
        if (redirect) begin
            case (r_state)
                S_IDLE:  w_state_next = S_REQ;
                S_REQ:   w_state_next = imem_gnt ? S_DROP : S_REQ;
                S_WAIT:  w_state_next = imem_rvalid ? S_REQ : S_DROP;
                default: w_state_next = S_DROP;
            endcase
        end else begin
            case (r_state)
                S_IDLE:  if (w_credit) w_state_next = S_REQ;
                S_REQ:   if (imem_gnt) w_state_next = S_WAIT;
                S_WAIT:  if (imem_rvalid) w_state_next = w_credit ? S_REQ : S_IDLE;
                default: if (imem_rvalid) w_state_next = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_next;
            if (redirect) begin
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                r_rd_ptr   <= r_wr_ptr;
                r_count    <= '0;
            end else begin
                if (w_grant) begin
                    r_req_pc   <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= w_count_next;
            end
        end
    end

    // NOTE: the buffer is reset because its head drives instr/instr_pc, which must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_buf_data[r_wr_ptr] <= imem_rdata;
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = r_buf_data[r_rd_ptr];
    assign instr_pc    = r_buf_pc[r_rd_ptr];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle tables and hand sequences, then random
// imem/decode/redirect traffic checked against a sequential-PC stream model.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rd_addr;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic vec_t mk(input logic r, g, rv, input logic [31:0] ra,
                                input logic rdy, rd, input logic [31:0] rpc,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.do_rst = r; v.gnt = g; v.rv = rv; v.rd_addr = ra; v.rdy = rdy;
        v.rd = rd; v.rpc = rpc; v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic g, rv, input logic [31:0] ra,
                         input logic rdy, rd, input logic [31:0] rpc);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(ra) : 32'h0;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic expect_out(input string name, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
        check({name, " imem_req"}, imem_req, req);
        check({name, " imem_addr"}, imem_addr, addr);
        check({name, " instr_valid"}, instr_valid, valid);
        if (valid) begin
            check({name, " instr_pc"}, instr_pc, pc);
            check({name, " instr"}, instr, mem_word(pc));
        end
    endtask

    // Ends on a falling edge with rst just released and no rising edge since.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset imem_req", imem_req, 0);
        check("reset imem_addr", imem_addr, RST_PC);
        check("reset instr_valid", instr_valid, 0);
        check("reset instr", instr, 0);
        check("reset instr_pc", instr_pc, 0);
        rst = 1'b0;
    endtask

    logic [31:0] m_addr, m_pc, mem_addr, rpc;
    logic        mem_pend, hold_prev, redir_prev, g, rv_real, rv_sp, rdy, rd;
    int          mem_wait, live, pops;

    initial begin
        // Startup at full rate: gnt every cycle, response one cycle later.
        vecs.push_back(mk(1, 1, 0, 0,      1, 0, 0, 0, 'h100, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      1, 0, 0, 1, 'h100, 0, 0));
        vecs.push_back(mk(0, 1, 1, 'h100,  1, 0, 0, 0, 'h104, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      1, 0, 0, 1, 'h104, 1, 'h100));
        vecs.push_back(mk(0, 1, 1, 'h104,  1, 0, 0, 0, 'h108, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      1, 0, 0, 1, 'h108, 1, 'h104));
        vecs.push_back(mk(0, 1, 1, 'h108,  1, 0, 0, 0, 'h10C, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 'h10C, 1, 'h108));
        // Backpressure: buffer fills with 0x100/0x104, then drains in order.
        vecs.push_back(mk(1, 1, 0, 0,      0, 0, 0, 0, 'h100, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0, 0, 1, 'h100, 0, 0));
        vecs.push_back(mk(0, 1, 1, 'h100,  0, 0, 0, 0, 'h104, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0, 0, 1, 'h104, 1, 'h100));
        vecs.push_back(mk(0, 1, 1, 'h104,  0, 0, 0, 0, 'h108, 1, 'h100));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0, 0, 0, 'h108, 1, 'h100));
        vecs.push_back(mk(0, 1, 0, 0,      1, 0, 0, 0, 'h108, 1, 'h100));
        vecs.push_back(mk(0, 1, 0, 0,      1, 0, 0, 1, 'h108, 1, 'h104));
        vecs.push_back(mk(0, 1, 1, 'h108,  1, 0, 0, 0, 'h10C, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,      1, 0, 0, 1, 'h10C, 1, 'h108));
        // Redirect while 0x104 is outstanding, then redirect in REQ without grant.
        vecs.push_back(mk(1, 1, 0, 0,      0, 0, 0,       0, 'h100,  0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0, 0,       1, 'h100,  0, 0));
        vecs.push_back(mk(0, 1, 1, 'h100,  0, 0, 0,       0, 'h104,  0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0, 0,       1, 'h104,  1, 'h100));
        vecs.push_back(mk(0, 0, 0, 0,      0, 1, 'h2002,  0, 'h108,  1, 'h100));
        vecs.push_back(mk(0, 0, 1, 'h104,  0, 0, 0,       0, 'h2000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      0, 0, 0,       1, 'h2000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 'h2000, 1, 0, 0,       0, 'h2004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,      1, 1, 'h3000,  1, 'h2004, 1, 'h2000));
        vecs.push_back(mk(0, 0, 0, 0,      1, 0, 0,       1, 'h3000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,      1, 0, 0,       1, 'h3000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 'h3000, 1, 0, 0,       0, 'h3004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,      1, 0, 0,       1, 'h3004, 1, 'h3000));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) do_reset();
            else @(negedge clk);
            expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                       vecs[i].e_valid, vecs[i].e_pc);
            apply(vecs[i].gnt, vecs[i].rv, vecs[i].rd_addr, vecs[i].rdy,
                  vecs[i].rd, vecs[i].rpc);
        end

        // Redirect coinciding with a grant: the granted response is dropped.
        do_reset();
        expect_out("drop0", 0, 'h100, 0, 0);  apply(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("drop1", 1, 'h100, 0, 0);  apply(1, 0, 0, 0, 1, 'h4001);
        @(negedge clk);
        expect_out("drop2", 0, 'h4000, 0, 0); apply(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("drop3", 0, 'h4000, 0, 0); apply(0, 1, 'h100, 0, 0, 0);
        @(negedge clk);
        expect_out("drop4", 1, 'h4000, 0, 0); apply(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("drop5", 0, 'h4004, 0, 0); apply(0, 1, 'h4000, 0, 0, 0);
        @(negedge clk);
        expect_out("drop6", 1, 'h4004, 1, 'h4000);
        // Fetch PC wraps from the top of the address space to zero.
        apply(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        @(negedge clk);
        expect_out("wrap0", 1, 32'hFFFF_FFFC, 0, 0); apply(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("wrap1", 0, 32'h0, 0, 0);         apply(0, 1, 32'hFFFF_FFFC, 1, 0, 0);
        @(negedge clk);
        expect_out("wrap2", 1, 32'h0, 1, 32'hFFFF_FFFC);

        // Random traffic: decode must see consecutive PCs restarting at each
        // redirect target, with never more than DEPTH words fetched ahead.
        do_reset();
        m_addr = RST_PC; m_pc = RST_PC; live = 0; pops = 0;
        mem_pend = 0; mem_wait = 0; mem_addr = 0; hold_prev = 0; redir_prev = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 1000 == 999) begin
                do_reset();
                m_addr = RST_PC; m_pc = RST_PC; live = 0; hold_prev = 0; redir_prev = 0;
            end else begin
                @(negedge clk);
            end
            if (redir_prev) check("rand valid_after_redirect", instr_valid, 0);
            if (hold_prev) check("rand req_held", imem_req, 1);
            if (imem_req) check("rand req_addr", imem_addr, m_addr);

            g       = ($urandom_range(0, 2) != 0);
            rv_real = mem_pend && (mem_wait == 0);
            rv_sp   = !mem_pend && ($urandom_range(0, 7) == 0);
            case ((cyc / 128) % 3)
                0:       rdy = ($urandom_range(0, 7) != 0);
                1:       rdy = ($urandom_range(0, 3) == 0);
                default: rdy = 1'b0;
            endcase
            rd  = ($urandom_range(0, 31) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;

            if (instr_valid && rdy && !rd) begin
                check("rand pop_pc", instr_pc, m_pc);
                check("rand pop_instr", instr, mem_word(m_pc));
                m_pc = m_pc + 32'd4;
                live--;
                pops++;
            end

            imem_gnt    = g;
            imem_rvalid = rv_real || rv_sp;
            imem_rdata  = rv_real ? mem_word(mem_addr) : 32'hDEAD_BEEF;
            instr_ready = rdy;
            redirect    = rd;
            redirect_pc = rpc;

            if (imem_req && g) begin
                mem_pend = 1'b1;
                mem_addr = imem_addr;
                mem_wait = $urandom_range(0, 2);
            end else if (rv_real) begin
                mem_pend = 1'b0;
            end else if (mem_pend && mem_wait > 0) begin
                mem_wait--;
            end

            if (rd) begin
                m_addr = rpc & 32'hFFFF_FFFC;
                m_pc   = rpc & 32'hFFFF_FFFC;
                live   = 0;
            end else if (imem_req && g) begin
                m_addr = m_addr + 32'd4;
                live++;
                check("rand occupancy_le_depth", (live <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
            end
            hold_prev  = imem_req && !g && !rd;
            redir_prev = rd;
        end
        check("rand progress", (pops >= 100) ? 32'd1 : 32'd0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
